// File: rtl/seq_restoring_divider_if.sv
// Start/done handshake and operand/result bus between an issuing controller and the divider.
// Controller owns start/operands; divider owns busy/done and the held results.
interface seq_restoring_divider_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_restoring_divider.sv
// Radix-2 restoring divider, one quotient bit per clock; DIV_SIGNED_EN selects two's-complement operands.
// Latency: done pulses WIDTH+1 cycles after accept (1 cycle for divide-by-zero).
// Backpressure: start is ignored while busy; a new start is taken in the done cycle.
module seq_restoring_divider #(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    seq_restoring_divider_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             zero_q, zero_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;
    logic             neg_quo_acc;
    logic             neg_rem_acc;

`ifdef DIV_SIGNED_EN
    logic neg_quo_q, neg_quo_d;
    logic neg_rem_q, neg_rem_d;

    // Divide magnitudes; signs are reapplied once the unsigned core finishes.
    assign dvd_mag     = bus.dividend[WIDTH-1] ? (~bus.dividend + 1'b1) : bus.dividend;
    assign dvs_mag     = bus.divisor[WIDTH-1]  ? (~bus.divisor  + 1'b1) : bus.divisor;
    assign neg_quo_acc = bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
    assign neg_rem_acc = bus.dividend[WIDTH-1];
    assign quo_fix     = neg_quo_q ? (~q_q + 1'b1) : q_q;
    assign rem_fix     = neg_rem_q ? (~r_q + 1'b1) : r_q;
`else
    assign dvd_mag     = bus.dividend;
    assign dvs_mag     = bus.divisor;
    assign neg_quo_acc = 1'b0;
    assign neg_rem_acc = 1'b0;
    assign quo_fix     = q_q;
    assign rem_fix     = r_q;
`endif

    // Trial subtract P - divisor as a + ~b + 1 through a ripple full-adder chain.
    // The partial remainder only reaches the top bit on the final step, so
    // dropping r_q's MSB when forming P loses nothing.
    logic [WIDTH-1:0] p;
    logic [WIDTH:0]   a_ext;
    logic [WIDTH:0]   b_ext;
    logic [WIDTH:0]   t;
    logic             cy;

    assign p     = {r_q[WIDTH-2:0], d_q[WIDTH-1]};
    assign a_ext = {1'b0, p};
    assign b_ext = ~{1'b0, dvs_q};

    always_comb begin
        cy = 1'b1;
        t  = '0;
        for (int i = 0; i <= WIDTH; i++) begin
            t[i] = a_ext[i] ^ b_ext[i] ^ cy;
            cy   = (a_ext[i] & b_ext[i]) | (cy & (a_ext[i] ^ b_ext[i]));
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        d_d     = d_q;
        r_d     = r_q;
        q_d     = q_q;
        dvs_d   = dvs_q;
        zero_d  = zero_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
`ifdef DIV_SIGNED_EN
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    busy_d  = 1'b1;
                    count_d = '0;
                    r_d     = '0;
                    q_d     = '0;
                    dvs_d   = dvs_mag;
                    quot_d  = '0;
                    rem_d   = '0;
                    dbz_d   = 1'b0;
                    if (bus.divisor == '0) begin
                        // Keep the raw dividend: it is returned as the remainder.
                        zero_d  = 1'b1;
                        d_d     = bus.dividend;
                        state_d = S_FIN;
`ifdef DIV_SIGNED_EN
                        neg_quo_d = 1'b0;
                        neg_rem_d = 1'b0;
`endif
                    end else begin
                        zero_d  = 1'b0;
                        d_d     = dvd_mag;
                        state_d = S_RUN;
`ifdef DIV_SIGNED_EN
                        neg_quo_d = neg_quo_acc;
                        neg_rem_d = neg_rem_acc;
`endif
                    end
                end
            end
            S_RUN: begin
                d_d = {d_q[WIDTH-2:0], 1'b0};
                if (!t[WIDTH]) begin
                    r_d = t[WIDTH-1:0];
                    q_d = {q_q[WIDTH-2:0], 1'b1};
                end else begin
                    r_d = p;
                    q_d = {q_q[WIDTH-2:0], 1'b0};
                end
                count_d = count_q + 1'b1;
                if (count_q == CW'(WIDTH - 1)) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                if (zero_q) begin
                    quot_d = '1;
                    rem_d  = d_q;
                    dbz_d  = 1'b1;
                end else begin
                    quot_d = quo_fix;
                    rem_d  = rem_fix;
                    dbz_d  = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            count_q <= '0;
            d_q     <= '0;
            r_q     <= '0;
            q_q     <= '0;
            dvs_q   <= '0;
            zero_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            d_q     <= d_d;
            r_q     <= r_d;
            q_q     <= q_d;
            dvs_q   <= dvs_d;
            zero_q  <= zero_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
`ifdef DIV_SIGNED_EN
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
`endif
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quot_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Randomized and directed checks of seq_restoring_divider against an arithmetic reference model.
module tb_seq_restoring_divider;
    localparam int W = 8;

    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;

    seq_restoring_divider_if #(.WIDTH(W)) bus ();

    seq_restoring_divider #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {dbz, quotient, remainder} from plain integer division.
    function automatic logic [2*W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] qq;
        logic [W-1:0] rr;
        int sa;
        int sb;
        int iq;
        int ir;
        if (b == '0) return {1'b1, {W{1'b1}}, a};
`ifdef DIV_SIGNED_EN
        sa = int'($signed(a));
        sb = int'($signed(b));
`else
        sa = int'(a);
        sb = int'(b);
`endif
        iq = sa / sb;
        ir = sa % sb;
        qq = iq[W-1:0];
        rr = ir[W-1:0];
        return {1'b0, qq, rr};
    endfunction

    function automatic logic [2*W:0] observed();
        return {bus.div_by_zero, bus.quotient, bus.remainder};
    endfunction

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(posedge clk); #1;
        bus.start    = 1'b0;
        bus.dividend = W'($urandom);
        bus.divisor  = W'($urandom);
    endtask

    // Bounded wait for done; counts cycles and busy samples from the current sample point.
    task automatic wait_done(output int lat, output int busy_cyc);
        lat      = 0;
        busy_cyc = bus.busy ? 1 : 0;
        while (!bus.done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (bus.busy) busy_cyc++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.dividend = '0;
        bus.divisor = '0;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if ({bus.busy, bus.done, observed()} !== '0) begin
            tests_failed++;
            $display("FAIL reset_hold: got %h, expected 0", {bus.busy, bus.done, observed()});
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if ({bus.busy, bus.done, observed()} !== '0) begin
            tests_failed++;
            $display("FAIL reset_release: got %h, expected 0", {bus.busy, bus.done, observed()});
        end
    endtask

    task automatic test_basic();
        int lat, bc;
        logic [2*W:0] exp_v;
        exp_v = model(8'd200, 8'd7);
        issue(8'd200, 8'd7);
        tests_run++;
        if ({bus.busy, bus.done} !== 2'b10) begin
            tests_failed++;
            $display("FAIL basic_accept: busy/done %b, expected 10", {bus.busy, bus.done});
        end
        wait_done(lat, bc);
        tests_run++;
        if (lat !== W + 1 || bc !== W + 1) begin
            tests_failed++;
            $display("FAIL basic_latency: lat %0d busy %0d, expected %0d", lat, bc, W + 1);
        end
        tests_run++;
        if (observed() !== exp_v || bus.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_result: got %h busy %b, expected %h", observed(), bus.busy, exp_v);
        end
        @(posedge clk); #1;
        tests_run++;
        if (bus.done !== 1'b0 || observed() !== exp_v) begin
            tests_failed++;
            $display("FAIL basic_hold: done %b res %h, expected 0 %h", bus.done, observed(), exp_v);
        end
    endtask

    task automatic test_div_zero();
        int lat, bc;
        issue(8'd13, 8'd0);
        wait_done(lat, bc);
        tests_run++;
        if (lat !== 1 || bc !== 1) begin
            tests_failed++;
            $display("FAIL dbz_latency: lat %0d busy %0d, expected 1 1", lat, bc);
        end
        tests_run++;
        if (observed() !== {1'b1, 8'hFF, 8'd13}) begin
            tests_failed++;
            $display("FAIL dbz_result: got %h, expected %h", observed(), {1'b1, 8'hFF, 8'd13});
        end
    endtask

    task automatic test_corners();
        logic [W-1:0] ta [4];
        logic [W-1:0] tb [4];
        int lat, bc;
        logic [2*W:0] exp_v;
        ta = '{8'd255, 8'd5, 8'd0, 8'd255};
        tb = '{8'd1,   8'd9, 8'd3, 8'd255};
        for (int i = 0; i < 4; i++) begin
            exp_v = model(ta[i], tb[i]);
            issue(ta[i], tb[i]);
            tests_run++;
            if (observed() !== '0) begin
                tests_failed++;
                $display("FAIL corner_clear_%0d: got %h, expected 0", i, observed());
            end
            wait_done(lat, bc);
            tests_run++;
            if (observed() !== exp_v || lat !== W + 1) begin
                tests_failed++;
                $display("FAIL corner_%0d: got %h lat %0d, expected %h lat %0d", i, observed(), lat, exp_v, W + 1);
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        logic [2*W:0] exp_a;
        logic [2*W:0] exp_b;
        exp_a = model(8'd100, 8'd10);
        exp_b = model(8'd50, 8'd5);
        issue(8'd100, 8'd10);
        repeat (2) begin @(posedge clk); #1; end
        bus.start = 1'b1; bus.dividend = 8'd50; bus.divisor = 8'd5;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.dividend = 8'd3; bus.divisor = 8'd1;
        wait_done(lat, bc);
        tests_run++;
        if (observed() !== exp_a || lat !== W - 2) begin
            tests_failed++;
            $display("FAIL busy_ignore: got %h lat %0d, expected %h lat %0d", observed(), lat, exp_a, W - 2);
        end
        issue(8'd50, 8'd5);
        tests_run++;
        if ({bus.busy, bus.done, observed()} !== {2'b10, {(2*W+1){1'b0}}}) begin
            tests_failed++;
            $display("FAIL b2b_accept: got %h, expected busy only", {bus.busy, bus.done, observed()});
        end
        wait_done(lat, bc);
        tests_run++;
        if (observed() !== exp_b || lat !== W + 1) begin
            tests_failed++;
            $display("FAIL b2b_result: got %h lat %0d, expected %h lat %0d", observed(), lat, exp_b, W + 1);
        end
    endtask

    task automatic test_reset_abort();
        int lat, bc, dones;
        issue(8'd200, 8'd7);
        repeat (3) begin @(posedge clk); #1; end
        #3 rst_n = 1'b0;
        #1;
        tests_run++;
        if ({bus.busy, bus.done, observed()} !== '0) begin
            tests_failed++;
            $display("FAIL abort_clear: got %h, expected 0", {bus.busy, bus.done, observed()});
        end
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (bus.done || bus.busy) dones++;
        end
        tests_run++;
        if (dones !== 0) begin
            tests_failed++;
            $display("FAIL abort_no_done: active cycles %0d, expected 0", dones);
        end
        issue(8'd9, 8'd2);
        wait_done(lat, bc);
        tests_run++;
        if (observed() !== model(8'd9, 8'd2) || lat !== W + 1) begin
            tests_failed++;
            $display("FAIL abort_recover: got %h lat %0d, expected %h", observed(), lat, model(8'd9, 8'd2));
        end
    endtask

    task automatic test_signed();
`ifdef DIV_SIGNED_EN
        logic [W-1:0] sa [3];
        logic [W-1:0] sb [3];
        logic [2*W:0] se [3];
        int lat, bc;
        sa = '{8'hF9, 8'h07, 8'h80};
        sb = '{8'h02, 8'hFE, 8'hFF};
        se = '{{1'b0, 8'hFD, 8'hFF}, {1'b0, 8'hFD, 8'h01}, {1'b0, 8'h80, 8'h00}};
        for (int i = 0; i < 3; i++) begin
            issue(sa[i], sb[i]);
            wait_done(lat, bc);
            tests_run++;
            if (observed() !== se[i]) begin
                tests_failed++;
                $display("FAIL signed_%0d: got %h, expected %h", i, observed(), se[i]);
            end
        end
`endif
    endtask

    task automatic test_random();
        logic [W-1:0] a, b;
        logic [2*W:0] exp_v;
        int lat, bc, bad;
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            a = W'($urandom);
            b = ($urandom_range(0, 15) == 0) ? '0 : W'($urandom);
            exp_v = model(a, b);
            issue(a, b);
            wait_done(lat, bc);
            tests_run++;
            if (observed() !== exp_v || lat !== ((b == '0) ? 1 : W + 1)) begin
                tests_failed++;
                bad++;
                if (bad < 10)
                    $display("FAIL random_%0d: %h/%h got %h lat %0d, expected %h", i, a, b, observed(), lat, exp_v);
            end
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        test_reset();
        test_basic();
        test_div_zero();
        test_corners();
        test_back_to_back();
        test_reset_abort();
        test_signed();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
